mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 5-stage pipelined CPU. Sits between the ID/EX pipeline register with the execute ALU, and the register-file write-back.
- Owns the EX/MEM register, drives the data-memory interface with a req/ready handshake, and produces the MEM/WB register contents.
- Supplies EX/MEM forwarding values to the forwarding logic.
- Back-pressures upstream stages with a stall while a memory access is outstanding.

Parameters:
- TIMEOUT, 16: maximum wait cycles for mem_ready before the access is declared failed (range 1..255).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX stage presents a valid instruction.
- ex_memread  in  1  instruction is a load (LW).
- ex_memwrite  in  1  instruction is a store (SW).
- ex_memtoreg  in  1  write-back selects the memory read data.
- ex_writereg  in  1  instruction writes the register file.
- ex_pcs  in  1  write-back selects ex_next_pc (PCS).
- ex_hlt  in  1  instruction is HLT.
- ex_dstreg  in  4  destination register.
- ex_alu_out  in  16  ALU result.
- ex_addr  in  16  effective memory address.
- ex_store_data  in  16  store data.
- ex_next_pc  in  16  PC+2 or branch target, for PCS.
- stall  out  1  upstream must hold; EX/MEM does not capture this cycle.
- mem_req  out  1  data memory request.
- mem_wr  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  16  word-aligned address.
- mem_wdata  out  16  store data.
- mem_rdata  in  16  read data, valid when mem_ready is high.
- mem_ready  in  1  memory completes the access this cycle.
- fwd_valid  out  1  EX/MEM holds a register-writing instruction.
- fwd_dstreg  out  4  EX/MEM destination register.
- fwd_data  out  16  EX/MEM ALU result, or next_pc if PCS.
- wb_valid  out  1  MEM/WB register valid.
- wb_writereg  out  1  register-file write enable.
- wb_dstreg  out  4  register-file destination.
- wb_data  out  16  register-file write data.
- wb_hlt  out  1  HLT reached write-back.
- err  out  1  sticky memory timeout flag.

Behaviour:
- Reset (asynchronous, rst high): all registers and outputs are 0.
  - FSM enters IDLE; mem_req drops in the same instant.
  - An in-flight access is abandoned; no write-back occurs for it.
- EX/MEM register:
  - On a rising edge with !stall, captures all ex_* inputs.
  - When ex_valid=0, captures a bubble: valid=0 and all control bits 0.
- Memory op: EX/MEM valid with memread or memwrite set.
- Memory outputs:
  - mem_req = valid & memop & state!=ERR.
  - mem_addr = addr & 16'hFFFE.
  - mem_wr = memwrite.
  - mem_wdata = store_data.
  - All held stable while mem_req is high and mem_ready is low.
- stall = (valid & memop & ~mem_ready) | (state==ERR). It is combinational, so a zero-wait memory (ready in the same cycle) never stalls.
- FSM states:
  - IDLE: no outstanding wait. Go to WAIT when mem_req & ~mem_ready; the wait counter loads 1.
  - WAIT: counter increments each cycle mem_ready is low. On mem_ready, return to IDLE. If the counter reaches TIMEOUT with mem_ready still low, go to ERR.
  - ERR: err=1, mem_req=0, stall=1, wb_valid=0 every cycle. Exits only on reset.
- Counter width: 8 bits, cleared on leaving WAIT.
- MEM/WB register: updates on every edge where stall=0 (the MEM/WB transfer happens on the same edge as the mem_ready handshake).
  - wb_valid = valid.
  - wb_writereg = valid & writereg.
  - wb_dstreg = dstreg.
  - wb_hlt = valid & hlt.
  - wb_data selection, in priority order: pcs → next_pc; memtoreg → mem_rdata; otherwise alu_out.
  - When stall=1, MEM/WB loads a bubble (wb_valid=0, wb_writereg=0), so a write-back is never duplicated.
- Latency: one cycle from EX/MEM capture to MEM/WB for non-memory ops and zero-wait memory ops; each wait cycle adds one.
- Stores never assert wb_writereg, since upstream control clears writereg for SW.
- A mem_ready seen while mem_req=0 is ignored.
- Forwarding:
  - fwd_valid = valid & writereg & ~memread, because load data is not forwardable from MEM; the hazard unit inserts the load-use bubble.
  - fwd_data = pcs ? next_pc : alu_out.
- HLT passes through like a non-memory op; halting the PC remains upstream's responsibility.

Decomposition:
- Shared package `cpu_pkg`: the 16-bit data/address width constant, the 4-bit register-index width, the FSM state encoding (IDLE=2'b00, WAIT=2'b01, ERR=2'b10), and the EX/MEM bundle struct.
- Natural sub-module `mem_access_fsm`: owns the state, the wait counter, mem_req gating, stall and err. The EX/MEM and MEM/WB registers and the write-back mux stay in `mem_stage`.

Test Plan:
- Zero-wait load: ex_memread=1, ex_memtoreg=1, ex_writereg=1, ex_addr=16'h0013, ex_dstreg=3; mem_ready=1 and mem_rdata=16'hBEEF in the request cycle → mem_addr=16'h0012, stall never 1, next cycle wb_data=16'hBEEF, wb_dstreg=3, wb_writereg=1.
- Store with ready after 3 wait cycles: ex_memwrite=1, ex_addr=16'h0040, ex_store_data=16'h5A5A → stall=1 for exactly 3 cycles; mem_wr, mem_addr and mem_wdata stable throughout; following instruction captured on the ready edge; wb_writereg=0.
- ALU and PCS ops back-to-back:
  - ALU op: ex_alu_out=16'h1234, ex_dstreg=5 → wb_data=16'h1234 one cycle later; fwd_dstreg=5 and fwd_data=16'h1234 during its EX/MEM cycle.
  - PCS op: ex_next_pc=16'h0022 → wb_data=16'h0022.
- Timeout with TIMEOUT=4: load with mem_ready held 0 → err=1 after 4 wait cycles; mem_req=0 and stall=1 thereafter; wb_valid stays 0 for 20 more cycles.
- Reset mid-access: assert rst during the 2nd wait cycle of a load → mem_req, stall, err and wb_* all 0 immediately without a clock edge; after release, a new zero-wait load completes normally.
- HLT and bubbles: ex_valid=0 for 2 cycles, then ex_hlt=1 → wb_valid=0 for 2 cycles, then wb_hlt=1 and wb_writereg=0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_pkg
// Description : Shared widths, memory-access FSM encoding and EX/MEM bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int c_DATA_W = 16;
    localparam int c_REG_W  = 4;
    localparam int c_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR  = 2'b10
    } mem_state_e;

    typedef struct packed {
        logic                valid;
        logic                memread;
        logic                memwrite;
        logic                memtoreg;
        logic                writereg;
        logic                pcs;
        logic                hlt;
        logic [c_REG_W-1:0]  dstreg;
        logic [c_DATA_W-1:0] alu_out;
        logic [c_DATA_W-1:0] addr;
        logic [c_DATA_W-1:0] store_data;
        logic [c_DATA_W-1:0] next_pc;
    } exmem_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_fsm
// Description : Data-memory wait tracking: request gating, stall, timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_fsm
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_memop,
    input  logic i_mem_ready,
    output logic o_mem_req,
    output logic o_stall,
    output logic o_err
);

    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    mem_state_e         r_state_q, w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q, w_cnt_d;
    logic               w_in_err;

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_in_err  = (r_state_q == ST_ERR);
        o_err     = w_in_err;
        o_mem_req = i_memop & ~w_in_err;
        o_stall   = (i_memop & ~i_mem_ready) | w_in_err;

        case (r_state_q)
            ST_IDLE: begin
                // The request cycle itself counts as the first wait cycle.
                if (o_mem_req && !i_mem_ready) begin
                    if (c_LIMIT == c_ONE) begin
                        w_state_d = ST_ERR;
                        w_cnt_d   = '0;
                    end else begin
                        w_state_d = ST_WAIT;
                        w_cnt_d   = c_ONE;
                    end
                end
            end
            ST_WAIT: begin
                if (i_mem_ready || !i_memop) begin
                    w_state_d = ST_IDLE;
                    w_cnt_d   = '0;
                end else if (r_cnt_q + c_ONE == c_LIMIT) begin
                    w_state_d = ST_ERR;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt_q + c_ONE;
                end
            end
            ST_ERR: begin
                w_state_d = ST_ERR;
            end
            default: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : CPU memory stage: EX/MEM register, data-memory port, MEM/WB.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    input  logic                ex_memread,
    input  logic                ex_memwrite,
    input  logic                ex_memtoreg,
    input  logic                ex_writereg,
    input  logic                ex_pcs,
    input  logic                ex_hlt,
    input  logic [c_REG_W-1:0]  ex_dstreg,
    input  logic [c_DATA_W-1:0] ex_alu_out,
    input  logic [c_DATA_W-1:0] ex_addr,
    input  logic [c_DATA_W-1:0] ex_store_data,
    input  logic [c_DATA_W-1:0] ex_next_pc,
    output logic                stall,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [c_DATA_W-1:0] mem_addr,
    output logic [c_DATA_W-1:0] mem_wdata,
    input  logic [c_DATA_W-1:0] mem_rdata,
    input  logic                mem_ready,
    output logic                fwd_valid,
    output logic [c_REG_W-1:0]  fwd_dstreg,
    output logic [c_DATA_W-1:0] fwd_data,
    output logic                wb_valid,
    output logic                wb_writereg,
    output logic [c_REG_W-1:0]  wb_dstreg,
    output logic [c_DATA_W-1:0] wb_data,
    output logic                wb_hlt,
    output logic                err
);

    exmem_t              r_exmem_q, w_exmem_d;
    logic                w_memop;
    logic                w_stall;
    logic                r_wb_valid_q, w_wb_valid_d;
    logic                r_wb_writereg_q, w_wb_writereg_d;
    logic                r_wb_hlt_q, w_wb_hlt_d;
    logic [c_REG_W-1:0]  r_wb_dstreg_q, w_wb_dstreg_d;
    logic [c_DATA_W-1:0] r_wb_data_q, w_wb_data_d;

    assign w_memop = r_exmem_q.valid & (r_exmem_q.memread | r_exmem_q.memwrite);

    mem_access_fsm #(
        .TIMEOUT     (TIMEOUT)
    ) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .i_memop     (w_memop),
        .i_mem_ready (mem_ready),
        .o_mem_req   (mem_req),
        .o_stall     (w_stall),
        .o_err       (err)
    );

    always_comb begin
        w_exmem_d = r_exmem_q;
        if (!w_stall) begin
            w_exmem_d = '0;
            if (ex_valid) begin
                w_exmem_d.valid      = 1'b1;
                w_exmem_d.memread    = ex_memread;
                w_exmem_d.memwrite   = ex_memwrite;
                w_exmem_d.memtoreg   = ex_memtoreg;
                w_exmem_d.writereg   = ex_writereg;
                w_exmem_d.pcs        = ex_pcs;
                w_exmem_d.hlt        = ex_hlt;
                w_exmem_d.dstreg     = ex_dstreg;
                w_exmem_d.alu_out    = ex_alu_out;
                w_exmem_d.addr       = ex_addr;
                w_exmem_d.store_data = ex_store_data;
                w_exmem_d.next_pc    = ex_next_pc;
            end
        end
    end

    // A stalled cycle hands a bubble to write-back so no result is written twice.
    always_comb begin
        w_wb_valid_d    = 1'b0;
        w_wb_writereg_d = 1'b0;
        w_wb_hlt_d      = 1'b0;
        w_wb_dstreg_d   = '0;
        w_wb_data_d     = '0;
        if (!w_stall) begin
            w_wb_valid_d    = r_exmem_q.valid;
            w_wb_writereg_d = r_exmem_q.valid & r_exmem_q.writereg;
            w_wb_hlt_d      = r_exmem_q.valid & r_exmem_q.hlt;
            w_wb_dstreg_d   = r_exmem_q.dstreg;
            if (r_exmem_q.pcs) begin
                w_wb_data_d = r_exmem_q.next_pc;
            end else if (r_exmem_q.memtoreg) begin
                w_wb_data_d = mem_rdata;
            end else begin
                w_wb_data_d = r_exmem_q.alu_out;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exmem_q       <= '0;
            r_wb_valid_q    <= 1'b0;
            r_wb_writereg_q <= 1'b0;
            r_wb_hlt_q      <= 1'b0;
            r_wb_dstreg_q   <= '0;
            r_wb_data_q     <= '0;
        end else begin
            r_exmem_q       <= w_exmem_d;
            r_wb_valid_q    <= w_wb_valid_d;
            r_wb_writereg_q <= w_wb_writereg_d;
            r_wb_hlt_q      <= w_wb_hlt_d;
            r_wb_dstreg_q   <= w_wb_dstreg_d;
            r_wb_data_q     <= w_wb_data_d;
        end
    end

    assign stall       = w_stall;
    assign mem_wr      = r_exmem_q.memwrite;
    assign mem_addr    = r_exmem_q.addr & 16'hFFFE;
    assign mem_wdata   = r_exmem_q.store_data;

    // Load data only exists in MEM, so loads are not offered for forwarding.
    assign fwd_valid   = r_exmem_q.valid & r_exmem_q.writereg & ~r_exmem_q.memread;
    assign fwd_dstreg  = r_exmem_q.dstreg;
    assign fwd_data    = r_exmem_q.pcs ? r_exmem_q.next_pc : r_exmem_q.alu_out;

    assign wb_valid    = r_wb_valid_q;
    assign wb_writereg = r_wb_writereg_q;
    assign wb_hlt      = r_wb_hlt_q;
    assign wb_dstreg   = r_wb_dstreg_q;
    assign wb_data     = r_wb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage (directed table + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int c_TIMEOUT = 4;

    typedef struct packed {
        logic        valid, rd, wr, m2r, wreg, pcs, hlt;
        logic [3:0]  dst;
        logic [15:0] alu, addr, sdata, npc;
    } instr_t;

    typedef struct {
        instr_t      ins;
        logic        ready;
        logic [15:0] rdata;
        logic        e_stall, e_req, e_wr;
        logic [15:0] e_addr, e_wdata;
        logic        e_wbv, e_wbw, e_wbh;
        logic [3:0]  e_wbd;
        logic [15:0] e_wbdata;
        logic        e_fv;
        logic [3:0]  e_fd;
        logic [15:0] e_fdata;
        logic        e_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid, ex_memread, ex_memwrite, ex_memtoreg, ex_writereg, ex_pcs, ex_hlt;
    logic [3:0]  ex_dstreg;
    logic [15:0] ex_alu_out, ex_addr, ex_store_data, ex_next_pc;
    logic        stall, mem_req, mem_wr, mem_ready;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        fwd_valid, wb_valid, wb_writereg, wb_hlt, err;
    logic [3:0]  fwd_dstreg, wb_dstreg;
    logic [15:0] fwd_data, wb_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(c_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .ex_writereg(ex_writereg), .ex_pcs(ex_pcs),
        .ex_hlt(ex_hlt), .ex_dstreg(ex_dstreg), .ex_alu_out(ex_alu_out),
        .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_next_pc(ex_next_pc),
        .stall(stall), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .fwd_valid(fwd_valid), .fwd_dstreg(fwd_dstreg), .fwd_data(fwd_data),
        .wb_valid(wb_valid), .wb_writereg(wb_writereg), .wb_dstreg(wb_dstreg),
        .wb_data(wb_data), .wb_hlt(wb_hlt), .err(err)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic instr_t f_nop();
        instr_t i = '0;
        return i;
    endfunction
    function automatic instr_t f_alu(input logic [3:0] d, input logic [15:0] v);
        instr_t i = '0;
        i.valid = 1; i.wreg = 1; i.dst = d; i.alu = v;
        return i;
    endfunction
    function automatic instr_t f_ld(input logic [3:0] d, input logic [15:0] a);
        instr_t i = '0;
        i.valid = 1; i.rd = 1; i.m2r = 1; i.wreg = 1; i.dst = d; i.addr = a; i.alu = 16'h0BAD;
        return i;
    endfunction
    function automatic instr_t f_sw(input logic [15:0] a, input logic [15:0] s);
        instr_t i = '0;
        i.valid = 1; i.wr = 1; i.addr = a; i.sdata = s; i.alu = a;
        return i;
    endfunction
    function automatic instr_t f_pcs(input logic [3:0] d, input logic [15:0] n);
        instr_t i = '0;
        i.valid = 1; i.wreg = 1; i.pcs = 1; i.dst = d; i.npc = n; i.alu = 16'h7777;
        return i;
    endfunction
    function automatic instr_t f_hlt();
        instr_t i = '0;
        i.valid = 1; i.hlt = 1;
        return i;
    endfunction

    task automatic drive(input instr_t i);
        ex_valid = i.valid; ex_memread = i.rd; ex_memwrite = i.wr; ex_memtoreg = i.m2r;
        ex_writereg = i.wreg; ex_pcs = i.pcs; ex_hlt = i.hlt; ex_dstreg = i.dst;
        ex_alu_out = i.alu; ex_addr = i.addr; ex_store_data = i.sdata; ex_next_pc = i.npc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(f_nop());
        mem_ready = 1'b0;
        mem_rdata = '0;
        rst = 1'b1;
        #2;
        chk("rst_stall", {15'd0, stall}, 16'd0);
        chk("rst_req", {15'd0, mem_req}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        chk("rst_wbv", {15'd0, wb_valid}, 16'd0);
        tick();
        rst = 1'b0;
    endtask

    // ---------------- behavioural reference model for random stimulus ----
    instr_t      m_slot;
    int          m_wait;
    bit          m_dead;
    logic        m_wbv, m_wbw, m_wbh;
    logic [3:0]  m_wbd;
    logic [15:0] m_wbdata;

    task automatic model_reset();
        m_slot = '0; m_wait = 0; m_dead = 0;
        m_wbv = 0; m_wbw = 0; m_wbh = 0; m_wbd = '0; m_wbdata = '0;
    endtask

    function automatic instr_t rand_instr();
        instr_t i;
        int t = $urandom_range(0, 5);
        logic [3:0]  d = 4'($urandom);
        logic [15:0] v = 16'($urandom);
        logic [15:0] a = 16'($urandom);
        case (t)
            0: begin i = instr_t'({$urandom, $urandom, $urandom}); i.valid = 0; end
            1: i = f_alu(d, v);
            2: i = f_ld(d, a);
            3: i = f_sw(a, v);
            4: i = f_pcs(d, v);
            default: i = f_hlt();
        endcase
        return i;
    endfunction

    task automatic random_cycle();
        instr_t      in = rand_instr();
        logic        rdy = ($urandom_range(0, 3) != 0);
        logic [15:0] rd = 16'($urandom);
        bit          memop, e_stall, e_fv;
        drive(in);
        mem_ready = rdy;
        mem_rdata = rd;
        #2;
        memop   = m_slot.valid && (m_slot.rd || m_slot.wr);
        e_stall = (memop && !rdy) || m_dead;
        e_fv    = m_slot.valid && m_slot.wreg && !m_slot.rd;
        chk("r_stall", {15'd0, stall}, {15'd0, e_stall});
        chk("r_req", {15'd0, mem_req}, {15'd0, memop && !m_dead});
        chk("r_err", {15'd0, err}, {15'd0, m_dead});
        if (memop && !m_dead) begin
            chk("r_addr", mem_addr, {m_slot.addr[15:1], 1'b0});
            chk("r_wr", {15'd0, mem_wr}, {15'd0, m_slot.wr});
            if (m_slot.wr) chk("r_wdata", mem_wdata, m_slot.sdata);
        end
        chk("r_fv", {15'd0, fwd_valid}, {15'd0, e_fv});
        if (e_fv) begin
            chk("r_fd", {12'd0, fwd_dstreg}, {12'd0, m_slot.dst});
            chk("r_fdata", fwd_data, m_slot.pcs ? m_slot.npc : m_slot.alu);
        end
        chk("r_wbv", {15'd0, wb_valid}, {15'd0, m_wbv});
        chk("r_wbw", {15'd0, wb_writereg}, {15'd0, m_wbw});
        chk("r_wbh", {15'd0, wb_hlt}, {15'd0, m_wbh});
        if (m_wbw) begin
            chk("r_wbd", {12'd0, wb_dstreg}, {12'd0, m_wbd});
            chk("r_wbdata", wb_data, m_wbdata);
        end
        // advance the model by one clock
        if (e_stall) begin
            m_wbv = 0; m_wbw = 0; m_wbh = 0;
        end else begin
            m_wbv    = m_slot.valid;
            m_wbw    = m_slot.valid && m_slot.wreg;
            m_wbh    = m_slot.valid && m_slot.hlt;
            m_wbd    = m_slot.dst;
            m_wbdata = m_slot.pcs ? m_slot.npc : (m_slot.m2r ? rd : m_slot.alu);
        end
        if (!m_dead) begin
            if (memop && !rdy) begin
                m_wait++;
                if (m_wait >= c_TIMEOUT) m_dead = 1;
            end else begin
                m_wait = 0;
            end
        end
        if (!e_stall) m_slot = in.valid ? in : '0;
        tick();
    endtask

    vec_t tbl [13];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //         ins                    rdy   rdata     stl req wr addr      wdata     wbv wbw wbh wbd   wbdata    fv fd    fdata     err
        tbl[0]  = '{f_ld(3, 16'h0013),    1'b1, 16'h0000, 0,  0,  0, 16'h0000, 16'h0000, 0,  0,  0,  4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0};
        tbl[1]  = '{f_alu(5, 16'h1234),   1'b1, 16'hBEEF, 0,  1,  0, 16'h0012, 16'h0000, 0,  0,  0,  4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0};
        tbl[2]  = '{f_pcs(6, 16'h0022),   1'b0, 16'h0000, 0,  0,  0, 16'h0000, 16'h0000, 1,  1,  0,  4'd3, 16'hBEEF, 1, 4'd5, 16'h1234, 0};
        tbl[3]  = '{f_sw(16'h0040, 16'h5A5A), 1'b1, 16'h1111, 0, 0, 0, 16'h0000, 16'h0000, 1, 1,  0,  4'd5, 16'h1234, 1, 4'd6, 16'h0022, 0};
        tbl[4]  = '{f_alu(7, 16'h00AA),   1'b0, 16'h0000, 1,  1,  1, 16'h0040, 16'h5A5A, 1,  1,  0,  4'd6, 16'h0022, 0, 4'd0, 16'h0000, 0};
        tbl[5]  = '{f_alu(9, 16'hFFFF),   1'b0, 16'h0000, 1,  1,  1, 16'h0040, 16'h5A5A, 0,  0,  0,  4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0};
        tbl[6]  = '{f_alu(9, 16'hFFFF),   1'b0, 16'h0000, 1,  1,  1, 16'h0040, 16'h5A5A, 0,  0,  0,  4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0};
        tbl[7]  = '{f_alu(7, 16'h00AA),   1'b1, 16'h0000, 0,  1,  1, 16'h0040, 16'h5A5A, 0,  0,  0,  4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0};
        tbl[8]  = '{f_nop(),              1'b0, 16'h0000, 0,  0,  0, 16'h0000, 16'h0000, 1,  0,  0,  4'd0, 16'h0000, 1, 4'd7, 16'h00AA, 0};
        tbl[9]  = '{f_nop(),              1'b0, 16'h0000, 0,  0,  0, 16'h0000, 16'h0000, 1,  1,  0,  4'd7, 16'h00AA, 0, 4'd0, 16'h0000, 0};
        tbl[10] = '{f_hlt(),              1'b0, 16'h0000, 0,  0,  0, 16'h0000, 16'h0000, 0,  0,  0,  4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0};
        tbl[11] = '{f_nop(),              1'b0, 16'h0000, 0,  0,  0, 16'h0000, 16'h0000, 0,  0,  0,  4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0};
        tbl[12] = '{f_nop(),              1'b0, 16'h0000, 0,  0,  0, 16'h0000, 16'h0000, 1,  0,  1,  4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0};

        tick();
        do_reset();

        // ---- directed table: load, ALU, PCS, store with waits, bubbles, HLT
        for (int k = 0; k < 13; k++) begin
            drive(tbl[k].ins);
            mem_ready = tbl[k].ready;
            mem_rdata = tbl[k].rdata;
            #2;
            chk($sformatf("t%0d_stall", k), {15'd0, stall}, {15'd0, tbl[k].e_stall});
            chk($sformatf("t%0d_req", k), {15'd0, mem_req}, {15'd0, tbl[k].e_req});
            chk($sformatf("t%0d_err", k), {15'd0, err}, {15'd0, tbl[k].e_err});
            if (tbl[k].e_req) begin
                chk($sformatf("t%0d_wr", k), {15'd0, mem_wr}, {15'd0, tbl[k].e_wr});
                chk($sformatf("t%0d_addr", k), mem_addr, tbl[k].e_addr);
                chk($sformatf("t%0d_wdata", k), mem_wdata, tbl[k].e_wdata);
            end
            chk($sformatf("t%0d_wbv", k), {15'd0, wb_valid}, {15'd0, tbl[k].e_wbv});
            chk($sformatf("t%0d_wbw", k), {15'd0, wb_writereg}, {15'd0, tbl[k].e_wbw});
            chk($sformatf("t%0d_wbh", k), {15'd0, wb_hlt}, {15'd0, tbl[k].e_wbh});
            if (tbl[k].e_wbw) begin
                chk($sformatf("t%0d_wbd", k), {12'd0, wb_dstreg}, {12'd0, tbl[k].e_wbd});
                chk($sformatf("t%0d_wbdata", k), wb_data, tbl[k].e_wbdata);
            end
            chk($sformatf("t%0d_fv", k), {15'd0, fwd_valid}, {15'd0, tbl[k].e_fv});
            if (tbl[k].e_fv) begin
                chk($sformatf("t%0d_fd", k), {12'd0, fwd_dstreg}, {12'd0, tbl[k].e_fd});
                chk($sformatf("t%0d_fdata", k), fwd_data, tbl[k].e_fdata);
            end
            tick();
        end

        // ---- timeout: load never answered
        do_reset();
        drive(f_ld(2, 16'h0100));
        #2;
        chk("to_req_idle", {15'd0, mem_req}, 16'd0);
        tick();
        drive(f_nop());
        for (int k = 0; k < c_TIMEOUT; k++) begin
            #2;
            chk($sformatf("to_w%0d_stall", k), {15'd0, stall}, 16'd1);
            chk($sformatf("to_w%0d_req", k), {15'd0, mem_req}, 16'd1);
            chk($sformatf("to_w%0d_err", k), {15'd0, err}, 16'd0);
            tick();
        end
        for (int k = 0; k < 20; k++) begin
            mem_ready = k[0];
            #2;
            chk("to_err", {15'd0, err}, 16'd1);
            chk("to_req", {15'd0, mem_req}, 16'd0);
            chk("to_stall", {15'd0, stall}, 16'd1);
            chk("to_wbv", {15'd0, wb_valid}, 16'd0);
            tick();
        end

        // ---- reset during the second wait cycle of a load
        do_reset();
        drive(f_ld(4, 16'h0200));
        tick();
        drive(f_nop());
        #2;
        chk("rm_w1_stall", {15'd0, stall}, 16'd1);
        tick();
        #2;
        chk("rm_w2_req", {15'd0, mem_req}, 16'd1);
        rst = 1'b1;
        #1;
        chk("rm_req", {15'd0, mem_req}, 16'd0);
        chk("rm_stall", {15'd0, stall}, 16'd0);
        chk("rm_err", {15'd0, err}, 16'd0);
        chk("rm_wbv", {15'd0, wb_valid}, 16'd0);
        chk("rm_wbw", {15'd0, wb_writereg}, 16'd0);
        chk("rm_wbdata", wb_data, 16'd0);
        tick();
        rst = 1'b0;
        drive(f_ld(4, 16'h0031));
        mem_ready = 1'b1;
        mem_rdata = 16'hCAFE;
        tick();
        drive(f_nop());
        #2;
        chk("rm_ld_req", {15'd0, mem_req}, 16'd1);
        chk("rm_ld_addr", mem_addr, 16'h0030);
        chk("rm_ld_stall", {15'd0, stall}, 16'd0);
        tick();
        #2;
        chk("rm_ld_wbw", {15'd0, wb_writereg}, 16'd1);
        chk("rm_ld_wbd", {12'd0, wb_dstreg}, 16'd4);
        chk("rm_ld_wbdata", wb_data, 16'hCAFE);
        tick();

        // ---- randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            if (c % 100 == 0) begin
                do_reset();
                model_reset();
            end
            random_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
